// File: rtl/uart_reg_pkg.sv
// Shared constants and state encodings for the UART register bridge.
package uart_reg_pkg;

    localparam int DATA_W = 8;

    localparam logic [DATA_W-1:0] CMD_READ  = 8'h01;
    localparam logic [DATA_W-1:0] CMD_WRITE = 8'h02;
    localparam logic [DATA_W-1:0] CMD_BURST = 8'h03;
    localparam logic [DATA_W-1:0] ACK       = 8'hAC;
    localparam logic [DATA_W-1:0] NAK       = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_ARG,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_BUS_WAIT,
        ST_TX_SEND,
        ST_TX_WAIT
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_serdes.sv
// 8N1 UART receiver (2-FF synchroniser, mid-bit sampling) and transmitter
// sharing one bit-period setting.
module uart_serdes
    import uart_reg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_ferr,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_start,
    output logic              tx_busy,
    output logic              txd
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    rx_state_t         rx_st, rx_st_nx;
    logic              rx_meta, rx_sync, rx_prev;
    logic [CW-1:0]     rx_cnt;
    logic [2:0]        rx_bit;
    logic [DATA_W-1:0] rx_shift;
    logic              rx_tick;

    logic [CW-1:0]     tx_cnt;
    logic [3:0]        tx_bit;
    logic [DATA_W:0]   tx_frame;

    assign rx_tick = (rx_cnt == FULL);
    assign rx_data = rx_shift;

    // Start is a falling edge, so a low line left by a framing error is not re-read as a start.
    always_comb begin
        rx_st_nx = rx_st;
        unique case (rx_st)
            RX_IDLE:  if (rx_prev && !rx_sync) rx_st_nx = RX_START;
            RX_START: if (rx_cnt == HALF) rx_st_nx = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_st_nx = RX_STOP;
            RX_STOP:  if (rx_tick) rx_st_nx = RX_IDLE;
            default:  rx_st_nx = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_st    <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_meta  <= rxd;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_st    <= rx_st_nx;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (rx_st == RX_IDLE || rx_st_nx != rx_st || (rx_st == RX_DATA && rx_tick))
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + CW'(1);
            if (rx_st == RX_IDLE)
                rx_bit <= '0;
            else if (rx_st == RX_DATA && rx_tick)
                rx_bit <= rx_bit + 3'd1;
            if (rx_st == RX_STOP && rx_tick) begin
                rx_valid <= rx_sync;
                rx_ferr  <= !rx_sync;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rx_st == RX_DATA && rx_tick)
            rx_shift <= {rx_sync, rx_shift[DATA_W-1:1]};
    end

    // tx_bit: 0 = start bit, 1..8 = data bits, 9 = stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_busy <= 1'b0;
            txd     <= 1'b1;
            tx_cnt  <= '0;
            tx_bit  <= '0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                tx_busy <= 1'b1;
                txd     <= 1'b0;
                tx_cnt  <= '0;
                tx_bit  <= '0;
            end
        end else if (tx_cnt == FULL) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
                tx_busy <= 1'b0;
                txd     <= 1'b1;
            end else begin
                tx_bit <= tx_bit + 4'd1;
                txd    <= tx_frame[tx_bit];
            end
        end else begin
            tx_cnt <= tx_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!tx_busy && tx_start)
            tx_frame <= {1'b1, tx_data};
    end

endmodule

// File: rtl/uart_reg_bridge.sv
// UART command responder: parses READ/WRITE/BURST frames, drives the 8-bit
// register bus and returns read data or ack/nak bytes on TXD.
module uart_reg_bridge
    import uart_reg_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic              xipMCLK,
    input  logic              xipRESET,
    input  logic              ipRXD,
    output logic              opTXD,
    output logic [DATA_W-1:0] opREG_ADDR,
    output logic [DATA_W-1:0] opREG_WDATA,
    output logic              opREG_WE,
    output logic              opREG_RE,
    input  logic [DATA_W-1:0] ipREG_RDATA,
    output logic              opBUSY,
    output logic              opERR
);

    localparam int TMO_MAX = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W   = $clog2(TMO_MAX + 1);

    state_t            state, state_nx;
    logic [DATA_W-1:0] rx_data, tx_byte, cmd, frm_addr;
    logic              rx_valid, rx_ferr, tx_start, tx_busy;
    logic [8:0]        count;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              in_get, tmo_hit, bad_cmd, err_nx;

    uart_serdes #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_serdes (
        .clk      (xipMCLK),
        .rst      (xipRESET),
        .rxd      (ipRXD),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr),
        .tx_data  (tx_byte),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .txd      (opTXD)
    );

    assign in_get  = (state == ST_GET_ADDR) || (state == ST_GET_ARG);
    assign tmo_hit = (tmo_cnt == TMO_W'(TMO_MAX - 1));
    assign opBUSY  = (state != ST_IDLE);

    always_comb begin
        state_nx = state;
        tx_start = 1'b0;
        bad_cmd  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_READ || rx_data == CMD_WRITE || rx_data == CMD_BURST) begin
                        state_nx = ST_GET_ADDR;
                    end else begin
                        state_nx = ST_TX_SEND;
                        bad_cmd  = 1'b1;
                    end
                end
            end
            ST_GET_ADDR: begin
                if (rx_valid)     state_nx = (cmd == CMD_READ) ? ST_BUS_RD : ST_GET_ARG;
                else if (tmo_hit) state_nx = ST_IDLE;
            end
            ST_GET_ARG: begin
                if (rx_valid)     state_nx = (cmd == CMD_WRITE) ? ST_BUS_WR : ST_BUS_RD;
                else if (tmo_hit) state_nx = ST_IDLE;
            end
            ST_BUS_WR:   state_nx = ST_TX_SEND;
            ST_BUS_RD:   state_nx = ST_BUS_WAIT;
            ST_BUS_WAIT: state_nx = ST_TX_SEND;
            ST_TX_SEND: begin
                tx_start = 1'b1;
                state_nx = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (!tx_busy)
                    state_nx = (cmd == CMD_BURST && count > 9'd1) ? ST_BUS_RD : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign err_nx = rx_ferr || bad_cmd || (rx_valid && state != ST_IDLE && !in_get)
                 || (in_get && !rx_valid && tmo_hit);

    // Control: state, strobes, bus address/data (reset to zero), timeout, error pulse
    always_ff @(posedge xipMCLK) begin
        if (xipRESET) begin
            state       <= ST_IDLE;
            opREG_WE    <= 1'b0;
            opREG_RE    <= 1'b0;
            opREG_ADDR  <= '0;
            opREG_WDATA <= '0;
            opERR       <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            state    <= state_nx;
            opREG_WE <= (state_nx == ST_BUS_WR);
            opREG_RE <= (state_nx == ST_BUS_RD);
            opERR    <= err_nx;
            tmo_cnt  <= (in_get && !rx_valid && !tmo_hit) ? tmo_cnt + TMO_W'(1) : '0;
            if (state_nx == ST_BUS_WR) begin
                opREG_ADDR  <= frm_addr;
                opREG_WDATA <= rx_data;
            end else if (state_nx == ST_BUS_RD) begin
                if (state == ST_GET_ADDR)     opREG_ADDR <= rx_data;
                else if (state == ST_GET_ARG) opREG_ADDR <= frm_addr;
                else                          opREG_ADDR <= opREG_ADDR + 8'd1;
            end
        end
    end

    // Frame datapath: command, address, burst count, reply byte
    always_ff @(posedge xipMCLK) begin
        if (state == ST_IDLE && rx_valid) begin
            cmd     <= rx_data;
            tx_byte <= NAK;
        end
        if (state == ST_GET_ADDR && rx_valid)
            frm_addr <= rx_data;
        if (state == ST_GET_ARG && rx_valid)
            count <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
        if (state == ST_TX_WAIT && !tx_busy && count > 9'd1)
            count <= count - 9'd1;
        if (state == ST_BUS_WR)
            tx_byte <= ACK;
        if (state == ST_BUS_WAIT)
            tx_byte <= ipREG_RDATA;
    end

endmodule
